// File: rtl/rx_nrzi_unstuff.sv
// USB2 receive back end: NRZI decode, SYNC hunt, bit unstuffing, LSB-first byte
// assembly and EOP/stuff-error detection on 0..2 recovered bits per cycle.
module rx_nrzi_unstuff #(
  parameter int SYNC_ZEROS = 5,
  parameter int STUFF_LEN  = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] bit_in_i,
  input  logic [1:0] bit_cnt_i,
  input  logic       se0_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_active_o,
  output logic       rx_eop_o,
  output logic       rx_error_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  logic [1:0] state_q, state_d;
  logic       prev_q, prev_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] zeros_q, zeros_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       eop_q, eop_d;
  logic       err_q, err_d;

  logic [1:0] nb;
  logic       lvl;
  logic       dec;

  // Both bits of a slip cycle are walked in order; the second bit sees the
  // state left by the first, so a SYNC completing on bit 0 lets bit 1 be data.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    ones_d  = ones_q;
    zeros_d = zeros_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    lvl     = 1'b0;
    dec     = 1'b0;
    nb      = (bit_cnt_i == 2'd3) ? 2'd2 : bit_cnt_i;

    if (se0_i) begin
      zeros_d = 3'd0;
      if (state_q != S_IDLE) begin
        if (state_q == S_DATA) begin
          eop_d = 1'b1;
          err_d = (idx_q != 3'd0);
        end
        state_d = S_IDLE;
        prev_d  = 1'b1;
        ones_d  = 3'd0;
        idx_d   = 3'd0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (b < int'(nb)) begin
          lvl    = bit_in_i[b[0]];
          dec    = (lvl == prev_d);
          prev_d = lvl;
          case (state_d)
            S_IDLE: begin
              if (!dec) begin
                if (zeros_d != 3'd7) zeros_d = zeros_d + 3'd1;
              end else if ({29'd0, zeros_d} >= SYNC_ZEROS) begin
                state_d = S_DATA;
                ones_d  = 3'd1;
                idx_d   = 3'd0;
                zeros_d = 3'd0;
              end else begin
                zeros_d = 3'd0;
              end
            end
            S_DATA: begin
              if ({29'd0, ones_d} == STUFF_LEN) begin
                if (dec) begin
                  eop_d   = 1'b1;
                  err_d   = 1'b1;
                  state_d = S_ABORT;
                end else begin
                  ones_d = 3'd0;
                end
              end else begin
                ones_d  = dec ? ones_d + 3'd1 : 3'd0;
                shift_d = {dec, shift_d[7:1]};
                idx_d   = idx_d + 3'd1;
                if (idx_d == 3'd0) begin
                  data_d  = shift_d;
                  valid_d = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      prev_q  <= 1'b1;
      ones_q  <= 3'd0;
      zeros_q <= 3'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      ones_q  <= ones_d;
      zeros_q <= zeros_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign rx_active_o = (state_q == S_DATA);
  assign rx_eop_o    = eop_q;
  assign rx_error_o  = err_q;

endmodule

// File: tb/tb_rx_nrzi_unstuff.sv
// Bench: packets are built by a USB-style encoder (stuffing + NRZI) that tags
// each line symbol with the receiver event it must cause; the DUT is scored per cycle.
module tb_rx_nrzi_unstuff;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic [1:0] bit_in_i;
  logic [1:0] bit_cnt_i;
  logic       se0_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_active_o, rx_eop_o, rx_error_o;

  rx_nrzi_unstuff dut (
    .clock_i(clock_i), .reset_i(reset_i), .bit_in_i(bit_in_i), .bit_cnt_i(bit_cnt_i),
    .se0_i(se0_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_active_o(rx_active_o), .rx_eop_o(rx_eop_o), .rx_error_o(rx_error_o)
  );

  always #5 clock_i = ~clock_i;

  localparam int T_PL = 0, T_SYNC = 1, T_BYTE = 2, T_SERR = 3, T_EOP = 4, T_EOPE = 5;

  typedef struct {
    logic       se0;
    logic       lvl;
    int         tag;
    logic [7:0] b;
  } sym_t;

  sym_t        sq[$];
  logic [11:0] obs_q[$], exp_q[$];
  logic        cur;
  int          ones_e, idx_e;
  logic [7:0]  acc;
  logic        x_act;
  logic [7:0]  x_data;
  int          ncmp = 0, nfail = 0;
  int          pat[7] = '{1, 1, 2, 0, 1, 2, 0};

  task automatic push(input logic se0, input logic lvl, input int tag, input logic [7:0] b);
    sym_t s;
    s.se0 = se0; s.lvl = lvl; s.tag = tag; s.b = b;
    sq.push_back(s);
  endtask

  task automatic enc_reset();
    cur = 1'b1; ones_e = 0; idx_e = 0; acc = 8'd0;
    sq.delete(); obs_q.delete(); exp_q.delete();
  endtask

  task automatic add_idle(input int n);
    repeat (n) push(1'b0, 1'b1, T_PL, 8'd0);
    cur = 1'b1;
  endtask

  // nz level toggles (decoded 0s) followed by one hold (decoded 1)
  task automatic add_sync(input int nz, input bit ok);
    repeat (nz) begin cur = ~cur; push(1'b0, cur, T_PL, 8'd0); end
    push(1'b0, cur, ok ? T_SYNC : T_PL, 8'd0);
    if (ok) begin ones_e = 1; idx_e = 0; end
  endtask

  task automatic add_bit(input logic d);
    if (ones_e == 6) begin
      cur = ~cur; push(1'b0, cur, T_PL, 8'd0); ones_e = 0;
    end
    cur    = d ? cur : ~cur;
    ones_e = d ? ones_e + 1 : 0;
    acc    = {d, acc[7:1]};
    idx_e  = (idx_e + 1) % 8;
    push(1'b0, cur, (idx_e == 0) ? T_BYTE : T_PL, acc);
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) add_bit(v[i]);
  endtask

  task automatic add_eop();
    push(1'b1, 1'b0, (idx_e != 0) ? T_EOPE : T_EOP, 8'd0);
    push(1'b1, 1'b0, T_PL, 8'd0);
    ones_e = 0; idx_e = 0;
    add_idle(2);
  endtask

  task automatic add_stuff_err();
    while (ones_e < 6) add_bit(1'b1);
    push(1'b0, cur, T_SERR, 8'd0);
    repeat (5) push(1'b0, 1'($urandom), T_PL, 8'd0);
    push(1'b1, 1'b0, T_PL, 8'd0);
    push(1'b1, 1'b0, T_PL, 8'd0);
    ones_e = 0; idx_e = 0;
    add_idle(2);
  endtask

  // mode 0: 1 bit/cycle, 1: fixed slip pattern, 2: random bit_cnt 0..3
  task automatic run(input int mode);
    int   n, k, pi, guard;
    logic ev, ee, er;
    sym_t s;
    pi = 0; guard = 0;
    while (sq.size() > 0 && guard < 5000) begin
      case (mode)
        0:       n = 1;
        1:       n = pat[pi % 7];
        default: n = $urandom_range(0, 3);
      endcase
      pi++; guard++;
      bit_in_i = 2'($urandom); bit_cnt_i = 2'($urandom); se0_i = 1'b0;
      ev = 1'b0; ee = 1'b0; er = 1'b0;
      k = 0;
      if (sq[0].se0) begin
        se0_i = 1'b1;
        k = 1;
      end else begin
        k = (n >= 2) ? 2 : n;
        if (k == 2 && (sq.size() < 2 || sq[1].se0)) k = 1;
        bit_cnt_i = (n == 3 && k == 2) ? 2'd3 : 2'(k);
      end
      for (int b = 0; b < k; b++) begin
        s = sq.pop_front();
        if (!s.se0) bit_in_i[b] = s.lvl;
        case (s.tag)
          T_SYNC: x_act = 1'b1;
          T_BYTE: begin ev = 1'b1; x_data = s.b; end
          T_SERR: begin ee = 1'b1; er = 1'b1; x_act = 1'b0; end
          T_EOP:  begin ee = 1'b1; x_act = 1'b0; end
          T_EOPE: begin ee = 1'b1; er = 1'b1; x_act = 1'b0; end
          default: ;
        endcase
      end
      @(posedge clock_i); #1;
      exp_q.push_back({x_act, ee, er, ev, x_data});
      obs_q.push_back({rx_active_o, rx_eop_o, rx_error_o, rx_valid_o, rx_data_o});
    end
    if (sq.size() > 0) begin
      nfail++;
      $display("FAIL run_bound: %0d symbols left, required 0", sq.size());
    end
    se0_i = 1'b0; bit_cnt_i = 2'd0;
  endtask

  task automatic test_reset();
    ncmp++;
    if ({rx_active_o, rx_eop_o, rx_error_o, rx_valid_o, rx_data_o} !== 12'h000) begin
      nfail++;
      $display("FAIL reset_outputs: got %h want 000",
               {rx_active_o, rx_eop_o, rx_error_o, rx_valid_o, rx_data_o});
    end
  endtask

  task automatic test_clean();
    int nv;
    enc_reset(); add_idle(3); add_sync(7, 1); add_byte(8'hA5); add_byte(8'h3C); add_eop();
    run(0);
    nv = 0;
    foreach (exp_q[i]) begin
      ncmp++;
      if (obs_q[i] !== exp_q[i]) begin
        nfail++; $display("FAIL clean cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i][8]) nv++;
    end
    ncmp++;
    if (nv !== 2) begin nfail++; $display("FAIL clean_count: got %0d want 2", nv); end
  endtask

  task automatic test_stuffing();
    enc_reset(); add_idle(3); add_sync(7, 1); add_byte(8'hFF); add_byte(8'h00);
    add_byte(8'h7F); add_byte(8'hFE); add_eop();
    run(0);
    foreach (exp_q[i]) begin
      ncmp++;
      if (obs_q[i] !== exp_q[i]) begin
        nfail++; $display("FAIL stuffing cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stuff_error();
    enc_reset(); add_idle(3); add_sync(7, 1); add_byte(8'h5A); add_stuff_err();
    add_sync(7, 1); add_byte(8'h81); add_eop();
    run(0);
    foreach (exp_q[i]) begin
      ncmp++;
      if (obs_q[i] !== exp_q[i]) begin
        nfail++; $display("FAIL stuff_err cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_slip();
    enc_reset(); add_idle(3); add_sync(7, 1); add_byte(8'hA5); add_byte(8'h3C); add_eop();
    run(1);
    foreach (exp_q[i]) begin
      ncmp++;
      if (obs_q[i] !== exp_q[i]) begin
        nfail++; $display("FAIL slip cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_trunc_sync();
    logic seen;
    enc_reset(); add_idle(3); add_sync(5, 1); add_byte(8'hC3); add_eop();
    add_idle(2); add_sync(4, 0); add_idle(6);
    run(0);
    seen = 1'b0;
    foreach (exp_q[i]) begin
      ncmp++;
      if (obs_q[i] !== exp_q[i]) begin
        nfail++; $display("FAIL trunc_sync cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i][11]) seen = 1'b1;
    end
    ncmp++;
    if (seen !== 1'b1) begin nfail++; $display("FAIL trunc_accept5: active got 0 want 1"); end
  endtask

  task automatic test_misaligned_eop();
    enc_reset(); add_idle(3); add_sync(7, 1); add_byte(8'h96);
    for (int i = 0; i < 5; i++) add_bit(1'($urandom));
    add_eop();
    run(0);
    foreach (exp_q[i]) begin
      ncmp++;
      if (obs_q[i] !== exp_q[i]) begin
        nfail++; $display("FAIL misaligned cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    enc_reset(); add_idle(3); add_sync(7, 1); add_byte(8'h11);
    for (int i = 0; i < 3; i++) add_bit(1'b0);
    run(0);
    foreach (exp_q[i]) begin
      ncmp++;
      if (obs_q[i] !== exp_q[i]) begin
        nfail++; $display("FAIL reset_mid_pre cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    #2 reset_i = 1'b0;
    #1;
    ncmp++;
    if ({rx_active_o, rx_eop_o, rx_error_o, rx_valid_o, rx_data_o} !== 12'h000) begin
      nfail++;
      $display("FAIL reset_mid_async: got %h want 000",
               {rx_active_o, rx_eop_o, rx_error_o, rx_valid_o, rx_data_o});
    end
    @(posedge clock_i); #1;
    reset_i = 1'b1; x_act = 1'b0; x_data = 8'd0;
    enc_reset(); add_idle(3); add_sync(7, 1); add_byte(8'hE7); add_byte(8'h42); add_eop();
    run(0);
    foreach (exp_q[i]) begin
      ncmp++;
      if (obs_q[i] !== exp_q[i]) begin
        nfail++; $display("FAIL reset_mid_post cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    enc_reset(); add_idle(3);
    for (int p = 0; p < 12; p++) begin
      add_sync($urandom_range(5, 7), 1);
      repeat ($urandom_range(1, 5)) add_byte(8'($urandom));
      if (p % 4 == 3) add_stuff_err();
      else begin
        if (p % 4 == 2) add_bit(1'($urandom));
        add_eop();
      end
    end
    run(2);
    foreach (exp_q[i]) begin
      ncmp++;
      if (obs_q[i] !== exp_q[i]) begin
        nfail++; $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset_i = 1'b0; bit_in_i = 2'd0; bit_cnt_i = 2'd0; se0_i = 1'b0;
    x_act = 1'b0; x_data = 8'd0;
    repeat (2) @(posedge clock_i);
    #1;
    test_reset();
    reset_i = 1'b1;
    test_clean();
    test_stuffing();
    test_stuff_error();
    test_slip();
    test_trunc_sync();
    test_misaligned_eop();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
